// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit and its ALU decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10
  } mc_state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  function automatic logic [1:0] imm_format(input logic [6:0] op);
    logic [1:0] fmt;
    case (op)
      OP_SW:   fmt = IMM_S;
      OP_BR:   fmt = IMM_B;
      OP_JAL:  fmt = IMM_J;
      default: fmt = IMM_I;
    endcase
    return fmt;
  endfunction

  function automatic logic is_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's ALU-op class plus funct fields to an ALU control code.
module aludec
  import mc_pkg::*;
(
  input  logic       i_opb5,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic [1:0] i_aluop,
  output logic [3:0] o_alucrtl
);

  // sub is only selected for R-type; addi with imm[10]=1 must still add
  always_comb begin
    o_alucrtl = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucrtl = ALU_ADD;
      ALUOP_SUB: o_alucrtl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alucrtl = (i_funct7b5 & i_opb5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alucrtl = ALU_SLL;
          3'b010:  o_alucrtl = ALU_SLT;
          3'b011:  o_alucrtl = ALU_SLTU;
          3'b100:  o_alucrtl = ALU_XOR;
          3'b101:  o_alucrtl = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alucrtl = ALU_OR;
          3'b111:  o_alucrtl = ALU_AND;
          default: o_alucrtl = ALU_ADD;
        endcase
      end
      default: o_alucrtl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: sequences the shared ALU/memory datapath and
// drives every mux select and write enable (Moore outputs plus FETCH ready gating).
module mc_controller
  import mc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pcwrite,
  output logic       o_adrsrc,
  output logic       o_irwrite,
  output logic       o_memwrite,
  output logic       o_regwrite,
  output logic [1:0] o_resultsrc,
  output logic [1:0] o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_immsrc,
  output logic [3:0] o_alucrtl,
  output logic       o_illegal,
  output logic       o_instret,
  output logic [3:0] o_state
);

  mc_state_t  state_q, state_d;
  logic       pcwrite_s, irwrite_s, memwrite_s, regwrite_s, illegal_s, instret_s;
  logic [1:0] aluop_s;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BRANCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = i_op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = i_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = i_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; everything not named for a state stays at its zero default
  always_comb begin
    pcwrite_s   = 1'b0;
    o_adrsrc    = 1'b0;
    irwrite_s   = 1'b0;
    memwrite_s  = 1'b0;
    regwrite_s  = 1'b0;
    o_resultsrc = RES_ALUOUT;
    o_alusrca   = SRCA_PC;
    o_alusrcb   = SRCB_RS2;
    aluop_s     = ALUOP_ADD;
    illegal_s   = 1'b0;
    instret_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALURES;
        irwrite_s   = i_mem_ready;
        pcwrite_s   = i_mem_ready;
      end
      S_DECODE: begin
        o_alusrca = SRCA_OLDPC;
        o_alusrcb = SRCB_IMM;
        illegal_s = ~is_supported(i_op);
      end
      S_MEMADR: begin
        o_alusrca = SRCA_RS1;
        o_alusrcb = SRCB_IMM;
      end
      S_MEMREAD: o_adrsrc = 1'b1;
      S_MEMWB: begin
        o_resultsrc = RES_RDATA;
        regwrite_s  = 1'b1;
        instret_s   = 1'b1;
      end
      S_MEMWRITE: begin
        o_adrsrc   = 1'b1;
        memwrite_s = 1'b1;
        instret_s  = i_mem_ready;
      end
      S_EXECR: begin
        o_alusrca = SRCA_RS1;
        o_alusrcb = SRCB_RS2;
        aluop_s   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        o_alusrca = SRCA_RS1;
        o_alusrcb = SRCB_IMM;
        aluop_s   = ALUOP_FUNCT;
      end
      // ALUOut holds the jump target from DECODE; the ALU forms OldPC+4 for rd
      S_JAL: begin
        o_alusrca   = SRCA_OLDPC;
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALUOUT;
        pcwrite_s   = 1'b1;
      end
      S_ALUWB: begin
        o_resultsrc = RES_ALUOUT;
        regwrite_s  = 1'b1;
        instret_s   = 1'b1;
      end
      S_BRANCH: begin
        o_alusrca   = SRCA_RS1;
        o_alusrcb   = SRCB_RS2;
        aluop_s     = ALUOP_SUB;
        o_resultsrc = RES_ALUOUT;
        pcwrite_s   = i_zero ^ i_funct3[0];
        instret_s   = 1'b1;
      end
      default: begin
        pcwrite_s = 1'b0;
      end
    endcase
  end

  // Reset masks every enable and pulse combinationally, not just from the next edge
  assign o_pcwrite  = pcwrite_s  & ~i_rst;
  assign o_irwrite  = irwrite_s  & ~i_rst;
  assign o_memwrite = memwrite_s & ~i_rst;
  assign o_regwrite = regwrite_s & ~i_rst;
  assign o_illegal  = illegal_s  & ~i_rst;
  assign o_instret  = instret_s  & ~i_rst;
  assign o_immsrc   = imm_format(i_op);
  assign o_state    = state_q;

  aludec u_aludec (
    .i_opb5     (i_op[5]),
    .i_funct3   (i_funct3),
    .i_funct7b5 (i_funct7b5),
    .i_aluop    (aluop_s),
    .o_alucrtl  (o_alucrtl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios then random instructions,
// each checked cycle by cycle against an instruction-level expectation model.
module tb_mc_controller;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, irw, mw, rw;
    logic [1:0] res, a, b;
    logic       ill, ret;
    logic [3:0] alu;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst, i_funct7b5, i_zero, i_mem_ready;
  logic [6:0] i_op;
  logic [2:0] i_funct3;
  logic       o_pcwrite, o_adrsrc, o_irwrite, o_memwrite, o_regwrite, o_illegal, o_instret;
  logic [1:0] o_resultsrc, o_alusrca, o_alusrcb, o_immsrc;
  logic [3:0] o_alucrtl, o_state;

  int checks = 0;
  int errors = 0;
  int n_instr = 0;

  mc_controller dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_op(i_op), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
    .o_pcwrite(o_pcwrite), .o_adrsrc(o_adrsrc), .o_irwrite(o_irwrite),
    .o_memwrite(o_memwrite), .o_regwrite(o_regwrite), .o_resultsrc(o_resultsrc),
    .o_alusrca(o_alusrca), .o_alusrcb(o_alusrcb), .o_immsrc(o_immsrc),
    .o_alucrtl(o_alucrtl), .o_illegal(o_illegal), .o_instret(o_instret),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.st = o_state;     o.pcw = o_pcwrite;   o.adr = o_adrsrc;  o.irw = o_irwrite;
    o.mw = o_memwrite;  o.rw = o_regwrite;   o.res = o_resultsrc;
    o.a = o_alusrca;    o.b = o_alusrcb;     o.ill = o_illegal; o.ret = o_instret;
    o.alu = o_alucrtl;
    return o;
  endfunction

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e = '0;
    e.st  = st;
    e.alu = ALU_ADD;
    return e;
  endfunction

  function automatic exp_t fetch_wait();
    exp_t e = blank(S_FETCH);
    e.b   = SRCB_FOUR;
    e.res = RES_ALURES;
    return e;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BR || op == OP_JAL;
  endfunction

  function automatic logic [1:0] imm_exp(input logic [6:0] op);
    if (op == OP_SW) return 2'b01;
    else if (op == OP_BR) return 2'b10;
    else if (op == OP_JAL) return 2'b11;
    else return 2'b00;
  endfunction

  // RISC-V semantics of the arithmetic instruction itself
  function automatic logic [3:0] op_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == OP_R && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic int lat_of(input logic [6:0] op);
    if (op == OP_BR) return 3;
    else if (op == OP_LW) return 5;
    else return 4;
  endfunction

  // One instruction: wf ready-low FETCH cycles, wm ready-low memory cycles.
  // Ready code per cycle: 0 = low, 1 = high, 2 = random (should be ignored).
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input int wf, input int wm);
    exp_t e, o;
    exp_t q[$];
    int   rq[$];
    int   r, cyc, rets, ret_at, exp_lat;
    bit   mem;
    mem = (op == OP_LW || op == OP_SW);
    n_instr++;
    e = fetch_wait();
    for (int k = 0; k < wf; k++) begin q.push_back(e); rq.push_back(0); end
    e.pcw = 1'b1; e.irw = 1'b1; q.push_back(e); rq.push_back(1);
    e = blank(S_DECODE); e.a = SRCA_OLDPC; e.b = SRCB_IMM; e.ill = !legal(op);
    q.push_back(e); rq.push_back(2);
    if (mem) begin
      e = blank(S_MEMADR); e.a = SRCA_RS1; e.b = SRCB_IMM; q.push_back(e); rq.push_back(2);
      e = blank(op == OP_LW ? S_MEMREAD : S_MEMWRITE); e.adr = 1'b1; e.mw = (op == OP_SW);
      for (int k = 0; k < wm; k++) begin q.push_back(e); rq.push_back(0); end
      e.ret = (op == OP_SW); q.push_back(e); rq.push_back(1);
      if (op == OP_LW) begin
        e = blank(S_MEMWB); e.res = RES_RDATA; e.rw = 1'b1; e.ret = 1'b1;
        q.push_back(e); rq.push_back(2);
      end
    end else if (op == OP_R || op == OP_I || op == OP_JAL) begin
      if (op == OP_JAL) begin
        e = blank(S_JAL); e.a = SRCA_OLDPC; e.b = SRCB_FOUR; e.pcw = 1'b1;
      end else begin
        e = blank(op == OP_R ? S_EXECR : S_EXECI); e.a = SRCA_RS1;
        e.b = (op == OP_R) ? SRCB_RS2 : SRCB_IMM; e.alu = op_alu(op, f3, f7);
      end
      q.push_back(e); rq.push_back(2);
      e = blank(S_ALUWB); e.rw = 1'b1; e.ret = 1'b1; q.push_back(e); rq.push_back(2);
    end else if (op == OP_BR) begin
      e = blank(S_BRANCH); e.a = SRCA_RS1; e.b = SRCB_RS2; e.alu = ALU_SUB;
      e.pcw = z ^ f3[0]; e.ret = 1'b1; q.push_back(e); rq.push_back(2);
    end
    cyc = 0; rets = 0; ret_at = -1;
    while (q.size() > 0) begin
      e = q.pop_front();
      r = rq.pop_front();
      @(negedge i_clk);
      i_op = op; i_funct3 = f3; i_funct7b5 = f7; i_zero = z;
      i_mem_ready = (r == 2) ? 1'($urandom_range(0, 1)) : r[0];
      #1;
      cyc++;
      o = observe();
      chk($sformatf("i%0d_c%0d_ctl", n_instr, cyc), 32'(o), 32'(e));
      chk($sformatf("i%0d_c%0d_imm", n_instr, cyc), 32'(o_immsrc), 32'(imm_exp(op)));
      if (o_instret) begin rets++; ret_at = cyc; end
    end
    chk($sformatf("i%0d_instret_cnt", n_instr), 32'(rets), legal(op) ? 32'd1 : 32'd0);
    if (legal(op)) begin
      exp_lat = lat_of(op) + wf + (mem ? wm : 0);
      chk($sformatf("i%0d_latency", n_instr), 32'(ret_at), 32'(exp_lat));
    end
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int         cls;
    i_rst = 1'b1; i_op = OP_R; i_funct3 = 3'b000; i_funct7b5 = 1'b0;
    i_zero = 1'b0; i_mem_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    chk("reset_ctl", 32'(observe()), 32'(fetch_wait()));
    i_rst = 1'b0; i_mem_ready = 1'b0;

    run(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);   // add x10,x10,x11
    run(OP_LW, 3'b010, 1'b0, 1'b0, 0, 2);
    run(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0);  // beq, taken
    run(OP_BR, 3'b001, 1'b0, 1'b1, 0, 0);  // bne, not taken
    run(OP_SW, 3'b010, 1'b0, 1'b0, 0, 3);
    run(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0);
    run(OP_JAL, 3'b000, 1'b0, 1'b0, 1, 0);
    run(OP_I, 3'b101, 1'b1, 1'b0, 2, 0);   // srai
    run(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);   // sub

    // reset in the middle of a store's memory wait
    @(negedge i_clk); i_op = OP_SW; i_funct3 = 3'b010; i_mem_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    @(negedge i_clk); i_mem_ready = 1'b0;
    #1;
    chk("rst_pre_state", 32'(o_state), 32'(S_MEMWRITE));
    chk("rst_pre_memwrite", 32'(o_memwrite), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_mid_memwrite", 32'(o_memwrite), 32'd0);
    chk("rst_mid_ctl", 32'(observe()), 32'(fetch_wait()));
    @(negedge i_clk); i_mem_ready = 1'b1;
    #1;
    chk("rst_hold_ready_ctl", 32'(observe()), 32'(fetch_wait()));
    @(negedge i_clk); i_rst = 1'b0; i_mem_ready = 1'b0;
    run(OP_R, 3'b111, 1'b0, 1'b0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 7);
      f3  = 3'($urandom);
      case (cls)
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_I;
        4: begin op = OP_BR; f3 = {2'b00, 1'($urandom)}; end
        5: op = OP_JAL;
        6: op = OP_BR;
        default: begin
          op = 7'($urandom);
          while (legal(op)) op = 7'($urandom);
        end
      endcase
      if (cls == 6) f3 = {2'b00, 1'($urandom)};
      run(op, f3, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
